// File: rtl/aq_hpcp_ovf_ctrl.sv
// rtl/aq_hpcp_ovf_ctrl.sv - HPCP overflow collector: sticky status, PMU irq, counter freeze
module aq_hpcp_ovf_ctrl #(
  parameter int CNT_NUM = 32
) (
  input  logic               cnt_clk,
  input  logic               cpurst_b,
  input  logic [CNT_NUM-1:0] cnt_of_vec_i,
  input  logic               ovf_wen_i,
  input  logic [CNT_NUM-1:0] ovf_wdata_i,
  input  logic               mask_wen_i,
  input  logic [CNT_NUM-1:0] mask_wdata_i,
  input  logic               freeze_en_i,
  input  logic               lost_clr_i,
  output logic [CNT_NUM-1:0] ovf_status_o,
  output logic [CNT_NUM-1:0] ovf_mask_o,
  output logic               ovf_lost_o,
  output logic               hpcp_int_vld_o,
  output logic               hpcp_freeze_o,
  output logic               ovf_clk_en_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    FROZEN = 1'b1
  } state_e;

  state_e             state_q;
  logic [CNT_NUM-1:0] status_q, status_d;
  logic [CNT_NUM-1:0] mask_q, mask_d;
  logic               lost_q, lost_d;
  logic               int_q, int_d;
  logic               freeze_q;
  logic               lost_hit;

  always_comb begin
    status_d = (ovf_wen_i ? ovf_wdata_i : status_q) | cnt_of_vec_i;
    mask_d   = mask_wen_i ? mask_wdata_i : mask_q;
    // A repeat overflow only counts as lost if software is not clearing that bit now.
    lost_hit = |(cnt_of_vec_i & status_q & (ovf_wen_i ? ovf_wdata_i : {CNT_NUM{1'b1}}));
    lost_d   = lost_hit ? 1'b1 : (lost_clr_i ? 1'b0 : lost_q);
    int_d    = |(status_q & mask_q);
  end

  always_ff @(posedge cnt_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      status_q <= '0;
      mask_q   <= '0;
      lost_q   <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      lost_q   <= lost_d;
      int_q    <= int_d;
    end
  end

  always_ff @(posedge cnt_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= IDLE;
      freeze_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (freeze_en_i && |(cnt_of_vec_i & mask_q)) begin
            state_q  <= FROZEN;
            freeze_q <= 1'b1;
          end
        end
        FROZEN: begin
          if (!freeze_en_i || !(|(status_d & mask_q))) begin
            state_q  <= IDLE;
            freeze_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          freeze_q <= 1'b0;
        end
      endcase
    end
  end

  // Keep the ICG open for any input event or while registered state still has to settle.
  assign ovf_clk_en_o = (|cnt_of_vec_i) | ovf_wen_i | mask_wen_i | lost_clr_i
                      | (state_q != IDLE) | (int_q != int_d);

  assign ovf_status_o   = status_q;
  assign ovf_mask_o     = mask_q;
  assign ovf_lost_o     = lost_q;
  assign hpcp_int_vld_o = int_q;
  assign hpcp_freeze_o  = freeze_q;

endmodule

// File: tb/tb_aq_hpcp_ovf_ctrl.sv
// tb/tb_aq_hpcp_ovf_ctrl.sv - randomized and directed bench for aq_hpcp_ovf_ctrl
module tb_aq_hpcp_ovf_ctrl;

  logic        cnt_clk = 1'b0;
  logic        cpurst_b = 1'b0;
  logic [31:0] of_vec = '0;
  logic        ovf_wen = 1'b0;
  logic [31:0] ovf_wdata = '0;
  logic        mask_wen = 1'b0;
  logic [31:0] mask_wdata = '0;
  logic        freeze_en = 1'b0;
  logic        lost_clr = 1'b0;
  logic [31:0] ovf_status, ovf_mask;
  logic        ovf_lost, hpcp_int_vld, hpcp_freeze, ovf_clk_en;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [31:0] m_st, m_mask;
  logic        m_lost, m_int, m_frz;

  aq_hpcp_ovf_ctrl #(.CNT_NUM(32)) dut (
    .cnt_clk        (cnt_clk),
    .cpurst_b       (cpurst_b),
    .cnt_of_vec_i   (of_vec),
    .ovf_wen_i      (ovf_wen),
    .ovf_wdata_i    (ovf_wdata),
    .mask_wen_i     (mask_wen),
    .mask_wdata_i   (mask_wdata),
    .freeze_en_i    (freeze_en),
    .lost_clr_i     (lost_clr),
    .ovf_status_o   (ovf_status),
    .ovf_mask_o     (ovf_mask),
    .ovf_lost_o     (ovf_lost),
    .hpcp_int_vld_o (hpcp_int_vld),
    .hpcp_freeze_o  (hpcp_freeze),
    .ovf_clk_en_o   (ovf_clk_en)
  );

  always #5 cnt_clk = ~cnt_clk;

  task automatic model_reset();
    m_st = '0; m_mask = '0; m_lost = 1'b0; m_int = 1'b0; m_frz = 1'b0;
  endtask

  task automatic clear_strobes();
    of_vec = '0; ovf_wen = 1'b0; ovf_wdata = '0;
    mask_wen = 1'b0; mask_wdata = '0; lost_clr = 1'b0;
  endtask

  task automatic do_reset();
    clear_strobes();
    freeze_en = 1'b0;
    cpurst_b  = 1'b0;
    model_reset();
    @(posedge cnt_clk); #1;
    cpurst_b = 1'b1;
  endtask

  // One clock: check clock request against the model, advance model and DUT,
  // optionally compare every registered output, then drop one-shot strobes.
  task automatic step(input bit chk);
    logic [31:0] nst;
    bit ev, lost_ev, any_en_nxt, exp_clk;
    #1;
    exp_clk = (of_vec != 0) || ovf_wen || mask_wen || lost_clr || m_frz
              || (m_int != ((m_st & m_mask) != 0));
    checks++;
    if (ovf_clk_en !== exp_clk) begin
      errors++;
      $display("FAIL clk_en: got %0b expected %0b at %0t", ovf_clk_en, exp_clk, $time);
    end
    lost_ev = 0;
    for (int i = 0; i < 32; i++) begin
      ev = of_vec[i];
      nst[i] = ev ? 1'b1 : (ovf_wen ? ovf_wdata[i] : m_st[i]);
      if (ev && m_st[i] && !(ovf_wen && !ovf_wdata[i])) lost_ev = 1;
    end
    any_en_nxt = (nst & m_mask) != 0;
    @(posedge cnt_clk); #1;
    if (!m_frz) m_frz = freeze_en && ((of_vec & m_mask) != 0);
    else        m_frz = freeze_en && any_en_nxt;
    m_int  = (m_st & m_mask) != 0;
    m_st   = nst;
    if (mask_wen) m_mask = mask_wdata;
    if (lost_ev) m_lost = 1'b1;
    else if (lost_clr) m_lost = 1'b0;
    clear_strobes();
    if (chk) begin
      checks++;
      if (ovf_status !== m_st) begin
        errors++; $display("FAIL model_status: got %h expected %h", ovf_status, m_st);
      end
      checks++;
      if (ovf_mask !== m_mask) begin
        errors++; $display("FAIL model_mask: got %h expected %h", ovf_mask, m_mask);
      end
      checks++;
      if ({ovf_lost, hpcp_int_vld, hpcp_freeze} !== {m_lost, m_int, m_frz}) begin
        errors++;
        $display("FAIL model_flags(lost,int,frz): got %b%b%b expected %b%b%b",
                 ovf_lost, hpcp_int_vld, hpcp_freeze, m_lost, m_int, m_frz);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({ovf_status, ovf_mask, ovf_lost, hpcp_int_vld, hpcp_freeze, ovf_clk_en} !== '0) begin
      errors++;
      $display("FAIL reset_values: status=%h mask=%h lost=%b int=%b frz=%b clk_en=%b",
               ovf_status, ovf_mask, ovf_lost, hpcp_int_vld, hpcp_freeze, ovf_clk_en);
    end
    // drive into FROZEN with status all ones, then reset asynchronously
    freeze_en = 1'b1; mask_wen = 1'b1; mask_wdata = 32'h1; step(1);
    of_vec = 32'h1; step(1);
    ovf_wen = 1'b1; ovf_wdata = 32'hFFFF_FFFF; step(1);
    step(1);
    checks++;
    if (hpcp_freeze !== 1'b1 || ovf_status !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL pre_reset_frozen: frz=%b status=%h expected 1 ffffffff", hpcp_freeze, ovf_status);
    end
    freeze_en = 1'b0;
    cpurst_b = 1'b0;
    #1;
    checks++;
    if ({ovf_status, ovf_mask, ovf_lost, hpcp_int_vld, hpcp_freeze, ovf_clk_en} !== '0) begin
      errors++;
      $display("FAIL async_reset: status=%h mask=%h lost=%b int=%b frz=%b clk_en=%b expected all 0",
               ovf_status, ovf_mask, ovf_lost, hpcp_int_vld, hpcp_freeze, ovf_clk_en);
    end
    model_reset();
    @(posedge cnt_clk); #1;
    cpurst_b = 1'b1;
  endtask

  task automatic test_basic_irq();
    do_reset();
    mask_wen = 1'b1; mask_wdata = 32'h8; step(1);
    of_vec = 32'h8; step(1);
    checks++;
    if (ovf_status !== 32'h8 || hpcp_int_vld !== 1'b0) begin
      errors++; $display("FAIL irq_n1: status=%h int=%b expected 00000008 0", ovf_status, hpcp_int_vld);
    end
    step(1);
    checks++;
    if (hpcp_int_vld !== 1'b1) begin
      errors++; $display("FAIL irq_n2: int=%b expected 1", hpcp_int_vld);
    end
    ovf_wen = 1'b1; ovf_wdata = 32'h0; step(1);
    checks++;
    if (hpcp_int_vld !== 1'b1 || ovf_status !== 32'h0) begin
      errors++; $display("FAIL irq_clr_m1: int=%b status=%h expected 1 00000000", hpcp_int_vld, ovf_status);
    end
    step(1);
    checks++;
    if (hpcp_int_vld !== 1'b0) begin
      errors++; $display("FAIL irq_clr_m2: int=%b expected 0", hpcp_int_vld);
    end
  endtask

  task automatic test_set_vs_clear();
    do_reset();
    of_vec = 32'h20; ovf_wen = 1'b1; ovf_wdata = 32'h0; step(1);
    checks++;
    if (ovf_status !== 32'h20 || ovf_lost !== 1'b0) begin
      errors++; $display("FAIL set_vs_clr: status=%h lost=%b expected 00000020 0", ovf_status, ovf_lost);
    end
    // bit already set but being cleared: the repeat is not lost
    of_vec = 32'h20; ovf_wen = 1'b1; ovf_wdata = 32'h0; step(1);
    checks++;
    if (ovf_status !== 32'h20 || ovf_lost !== 1'b0) begin
      errors++; $display("FAIL set_vs_clr_set: status=%h lost=%b expected 00000020 0", ovf_status, ovf_lost);
    end
  endtask

  task automatic test_lost();
    do_reset();
    ovf_wen = 1'b1; ovf_wdata = 32'h80; step(1);
    of_vec = 32'h80; step(1);
    checks++;
    if (ovf_lost !== 1'b1) begin
      errors++; $display("FAIL lost_set: lost=%b expected 1", ovf_lost);
    end
    lost_clr = 1'b1; step(1);
    checks++;
    if (ovf_lost !== 1'b0) begin
      errors++; $display("FAIL lost_clr: lost=%b expected 0", ovf_lost);
    end
    lost_clr = 1'b1; of_vec = 32'h80; step(1);
    checks++;
    if (ovf_lost !== 1'b1) begin
      errors++; $display("FAIL lost_set_wins: lost=%b expected 1", ovf_lost);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    freeze_en = 1'b1; mask_wen = 1'b1; mask_wdata = 32'h1; step(1);
    of_vec = 32'h1; step(1);
    checks++;
    if (hpcp_freeze !== 1'b1) begin
      errors++; $display("FAIL freeze_enter: frz=%b expected 1", hpcp_freeze);
    end
    of_vec = 32'h4; step(1);
    checks++;
    if (ovf_status !== 32'h5 || hpcp_freeze !== 1'b1) begin
      errors++; $display("FAIL freeze_hold: status=%h frz=%b expected 00000005 1", ovf_status, hpcp_freeze);
    end
    ovf_wen = 1'b1; ovf_wdata = 32'h4; step(1);
    checks++;
    if (hpcp_freeze !== 1'b0 || ovf_status !== 32'h4) begin
      errors++; $display("FAIL freeze_exit: frz=%b status=%h expected 0 00000004", hpcp_freeze, ovf_status);
    end
    of_vec = 32'h1; step(1);
    ovf_wen = 1'b1; ovf_wdata = 32'h0; of_vec = 32'h1; step(1);
    checks++;
    if (hpcp_freeze !== 1'b1 || ovf_status !== 32'h1) begin
      errors++; $display("FAIL freeze_clr_and_set: frz=%b status=%h expected 1 00000001", hpcp_freeze, ovf_status);
    end
    freeze_en = 1'b0; step(1);
    checks++;
    if (hpcp_freeze !== 1'b0) begin
      errors++; $display("FAIL freeze_disable: frz=%b expected 0", hpcp_freeze);
    end
  endtask

  task automatic test_masked();
    do_reset();
    freeze_en = 1'b1;
    of_vec = 32'h200; step(1);
    checks++;
    if (ovf_status !== 32'h200 || hpcp_freeze !== 1'b0) begin
      errors++; $display("FAIL masked_status: status=%h frz=%b expected 00000200 0", ovf_status, hpcp_freeze);
    end
    step(1);
    checks++;
    if (hpcp_int_vld !== 1'b0 || hpcp_freeze !== 1'b0) begin
      errors++; $display("FAIL masked_quiet: int=%b frz=%b expected 0 0", hpcp_int_vld, hpcp_freeze);
    end
    mask_wen = 1'b1; mask_wdata = 32'h200; step(1);
    checks++;
    if (hpcp_int_vld !== 1'b0) begin
      errors++; $display("FAIL mask_open_m1: int=%b expected 0", hpcp_int_vld);
    end
    step(1);
    checks++;
    if (hpcp_int_vld !== 1'b1) begin
      errors++; $display("FAIL mask_open_m2: int=%b expected 1", hpcp_int_vld);
    end
    freeze_en = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0)
        of_vec = 32'h1 << $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0)
        of_vec = of_vec | ($urandom & $urandom);
      if ($urandom_range(0, 5) == 0) begin
        ovf_wen = 1'b1;
        ovf_wdata = ($urandom_range(0, 1) == 0) ? 32'h0 : (m_st & $urandom);
      end
      if ($urandom_range(0, 11) == 0) begin
        mask_wen = 1'b1;
        mask_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      end
      if ($urandom_range(0, 7) == 0) lost_clr = 1'b1;
      if ($urandom_range(0, 19) == 0) freeze_en = ~freeze_en;
      step(1);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_irq();
    test_set_vs_clear();
    test_lost();
    test_freeze();
    test_masked();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
